pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 24 ++
 rtl/tick_divider.sv | 35 +++
 rtl/pong_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller, paddles and ball.
package pong_pkg;

    localparam int unsigned SCORE_W     = 4;
    localparam int unsigned FRAME_CNT_W = 8;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        POINT = 3'd4,
        OVER  = 3'd5
    } game_state_e;

    // States in which the paddle dividers advance
    function automatic logic is_active(input game_state_e s);
        return (s == SERVE) || (s == PLAY);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides frame ticks by DIV; emits a registered one-cycle pulse after each wrap.
module tick_divider
    import pong_pkg::*;
#(
    parameter int unsigned DIV = 1,
    parameter int unsigned W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic tick,
    output logic pulse
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (run && tick) begin
                if (count == W'(DIV - 1)) begin
                    count <= '0;
                    pulse <= 1'b1;
                end else begin
                    count <= count + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/play/pause/point/over flow, scoring and paddle move enables.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned PLAYER_DIV   = 1,
    parameter int unsigned AI_DIV       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                start_btn,
    input  logic                pause_btn,
    input  logic                miss_left,
    input  logic                miss_right,
    output logic                ball_en,
    output logic                ball_reset,
    output logic                serve_dir,
    output logic                player_move_en,
    output logic                ai_move_en,
    output logic [SCORE_W-1:0]  score_player,
    output logic [SCORE_W-1:0]  score_ai,
    output logic                game_over,
    output logic                winner,
    output logic [2:0]          state
);

    localparam logic [SCORE_W-1:0]     WIN_S   = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SERVE_N = FRAME_CNT_W'(SERVE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] POINT_N = FRAME_CNT_W'(POINT_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

    game_state_e              state_q, state_d;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [SCORE_W-1:0]       score_player_d, score_ai_d;
    logic [SCORE_W-1:0]       player_inc, ai_inc;
    logic                     serve_dir_d, winner_d;
    logic                     start_prev, pause_prev;
    logic                     start_edge, pause_edge;
    logic                     div_clear, div_run;

    assign start_edge = start_btn & ~start_prev;
    assign pause_edge = pause_btn & ~pause_prev;
    assign state      = state_q;

    // State and registered outputs; status levels follow the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            score_player <= '0;
            score_ai     <= '0;
            serve_dir    <= SERVE_LEFT;
            winner       <= 1'b0;
            game_over    <= 1'b0;
            ball_en      <= 1'b0;
            ball_reset   <= 1'b1;
            start_prev   <= 1'b1;
            pause_prev   <= 1'b1;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            score_player <= score_player_d;
            score_ai     <= score_ai_d;
            serve_dir    <= serve_dir_d;
            winner       <= winner_d;
            game_over    <= (state_d == OVER);
            ball_en      <= (state_d == PLAY);
            ball_reset   <= !((state_d == PLAY) || (state_d == PAUSE));
            start_prev   <= start_btn;
            pause_prev   <= pause_btn;
        end
    end

    always_comb begin
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        score_player_d = score_player;
        score_ai_d     = score_ai;
        serve_dir_d    = serve_dir;
        winner_d       = winner;
        div_clear      = 1'b0;
        player_inc     = score_player + SCORE_W'(1);
        ai_inc         = score_ai + SCORE_W'(1);

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = SERVE;
                    frame_cnt_d = SERVE_N;
                    div_clear   = 1'b1;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q - CNT_ONE;
                    if (frame_cnt_q == CNT_ONE) state_d = PLAY;
                end
            end
            PLAY: begin
                // A simultaneous double miss is a replay: no score, direction kept
                if (miss_left && miss_right) begin
                    state_d     = POINT;
                    frame_cnt_d = POINT_N;
                end else if (miss_right) begin
                    score_player_d = player_inc;
                    serve_dir_d    = SERVE_RIGHT;
                    frame_cnt_d    = POINT_N;
                    if (player_inc == WIN_S) begin
                        state_d  = OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d  = POINT;
                    end
                end else if (miss_left) begin
                    score_ai_d  = ai_inc;
                    serve_dir_d = SERVE_LEFT;
                    frame_cnt_d = POINT_N;
                    if (ai_inc == WIN_S) begin
                        state_d  = OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d  = POINT;
                    end
                end else if (pause_edge) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_edge) state_d = PLAY;
            end
            POINT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == CNT_ONE) begin
                        state_d     = SERVE;
                        frame_cnt_d = SERVE_N;
                        div_clear   = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q - CNT_ONE;
                    end
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_d        = SERVE;
                    frame_cnt_d    = SERVE_N;
                    score_player_d = '0;
                    score_ai_d     = '0;
                    serve_dir_d    = SERVE_LEFT;
                    winner_d       = 1'b0;
                    div_clear      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ticks only advance the paddles while staying within serve/play
        div_run = is_active(state_q) && is_active(state_d);
    end

    tick_divider #(
        .DIV (PLAYER_DIV),
        .W   (4)
    ) u_player_div (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .run   (div_run),
        .tick  (frame_tick),
        .pulse (player_move_en)
    );

    tick_divider #(
        .DIV (AI_DIV),
        .W   (4)
    ) u_ai_div (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .run   (div_run),
        .tick  (frame_tick),
        .pulse (ai_move_en)
    );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed match scenarios, then random play against a reference model.
module tb_pong_game_ctrl;

    localparam int WIN  = 2;
    localparam int SRVN = 3;
    localparam int PNTN = 2;
    localparam int PDIV = 1;
    localparam int ADIV = 2;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_POINT = 4;
    localparam int S_OVER  = 5;

    logic       clk, reset, frame_tick, start_btn, pause_btn, miss_left, miss_right;
    logic       ball_en, ball_reset, serve_dir, player_move_en, ai_move_en, game_over, winner;
    logic [3:0] score_player, score_ai;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model of the match as seen after each clock edge
    int m_phase, m_ticks, m_sp, m_sa, m_dir, m_win;
    int m_pcnt, m_acnt, m_pm, m_am;
    bit m_start_prev, m_pause_prev;
    bit start_lvl, pause_lvl;

    pong_game_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SRVN),
        .POINT_FRAMES (PNTN),
        .PLAYER_DIV   (PDIV),
        .AI_DIV       (ADIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .start_btn      (start_btn),
        .pause_btn      (pause_btn),
        .miss_left      (miss_left),
        .miss_right     (miss_right),
        .ball_en        (ball_en),
        .ball_reset     (ball_reset),
        .serve_dir      (serve_dir),
        .player_move_en (player_move_en),
        .ai_move_en     (ai_move_en),
        .score_player   (score_player),
        .score_ai       (score_ai),
        .game_over      (game_over),
        .winner         (winner),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = S_IDLE; m_ticks = 0; m_sp = 0; m_sa = 0; m_dir = 0; m_win = 0;
        m_pcnt = 0; m_acnt = 0; m_pm = 0; m_am = 0;
        m_start_prev = 1'b1; m_pause_prev = 1'b1;
    endtask

    function automatic bit moving(input int p);
        return (p == S_SERVE) || (p == S_PLAY);
    endfunction

    task automatic model_update(input bit ft, input bit ml, input bit mr, input bit rs);
        bit st_e, pa_e, clr;
        int nxt;
        if (rs) begin
            model_reset();
            return;
        end
        st_e = start_lvl && !m_start_prev;
        pa_e = pause_lvl && !m_pause_prev;
        m_start_prev = start_lvl;
        m_pause_prev = pause_lvl;
        nxt = m_phase;
        clr = 1'b0;
        if (m_phase == S_IDLE && st_e) begin
            nxt = S_SERVE; m_ticks = 0; clr = 1'b1;
        end else if (m_phase == S_SERVE && ft) begin
            m_ticks++;
            if (m_ticks == SRVN) nxt = S_PLAY;
        end else if (m_phase == S_PLAY && (ml || mr)) begin
            m_ticks = 0;
            nxt = S_POINT;
            if (mr && !ml) begin
                m_sp++; m_dir = 1;
                if (m_sp == WIN) begin nxt = S_OVER; m_win = 0; end
            end else if (ml && !mr) begin
                m_sa++; m_dir = 0;
                if (m_sa == WIN) begin nxt = S_OVER; m_win = 1; end
            end
        end else if (m_phase == S_PLAY && pa_e) begin
            nxt = S_PAUSE;
        end else if (m_phase == S_PAUSE && pa_e) begin
            nxt = S_PLAY;
        end else if (m_phase == S_POINT && ft) begin
            m_ticks++;
            if (m_ticks == PNTN) begin nxt = S_SERVE; m_ticks = 0; clr = 1'b1; end
        end else if (m_phase == S_OVER && st_e) begin
            nxt = S_SERVE; m_ticks = 0; m_sp = 0; m_sa = 0; m_dir = 0; m_win = 0; clr = 1'b1;
        end
        m_pm = 0; m_am = 0;
        if (clr) begin
            m_pcnt = 0; m_acnt = 0;
        end else if (ft && moving(m_phase) && moving(nxt)) begin
            m_pcnt++; m_acnt++;
            m_pm = (m_pcnt % PDIV == 0) ? 1 : 0;
            m_am = (m_acnt % ADIV == 0) ? 1 : 0;
        end
        m_phase = nxt;
    endtask

    task automatic check_all();
        chk("state",      32'(state),          32'(m_phase));
        chk("ball_en",    32'(ball_en),        32'(m_phase == S_PLAY));
        chk("ball_reset", 32'(ball_reset),     32'(m_phase != S_PLAY && m_phase != S_PAUSE));
        chk("serve_dir",  32'(serve_dir),      32'(m_dir));
        chk("player_mv",  32'(player_move_en), 32'(m_pm));
        chk("ai_mv",      32'(ai_move_en),     32'(m_am));
        chk("score_pl",   32'(score_player),   32'(m_sp));
        chk("score_ai",   32'(score_ai),       32'(m_sa));
        chk("game_over",  32'(game_over),      32'(m_phase == S_OVER));
        chk("winner",     32'(winner),         32'(m_win));
    endtask

    // One clock: drive inputs, advance the model, sample just after the edge
    task automatic cyc(input bit ft = 0, input bit ml = 0, input bit mr = 0, input bit rs = 0);
        frame_tick = ft; miss_left = ml; miss_right = mr; reset = rs;
        start_btn = start_lvl; pause_btn = pause_lvl;
        model_update(ft, ml, mr, rs);
        @(posedge clk);
        #1;
        check_all();
        frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0; reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1);
            cyc();
        end
    endtask

    task automatic press_start();
        start_lvl = 1'b1; cyc();
        start_lvl = 1'b0; cyc();
    endtask

    task automatic press_pause();
        pause_lvl = 1'b1; cyc();
        pause_lvl = 1'b0; cyc();
    endtask

    initial begin
        int pcount, acount;
        frame_tick = 0; miss_left = 0; miss_right = 0; reset = 1;
        start_lvl = 1'b1; pause_lvl = 1'b0;
        start_btn = 1'b1; pause_btn = 1'b0;
        model_reset();

        // Start held high through reset release must not start a match
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        cyc(); cyc(); cyc();
        chk("held_start_idle", 32'(state), 32'(S_IDLE));
        chk("reset_ball_reset", 32'(ball_reset), 32'd1);
        start_lvl = 1'b0; cyc();

        // Start, then exactly SERVE_FRAMES ticks into play
        start_lvl = 1'b1; cyc();
        chk("start_serve", 32'(state), 32'(S_SERVE));
        start_lvl = 1'b0; cyc();
        cyc(1'b1); cyc(); cyc(1'b1); cyc();
        chk("serve_hold", 32'(state), 32'(S_SERVE));
        cyc(1'b1);
        chk("play_entry", 32'(state), 32'(S_PLAY));
        chk("play_ball_en", 32'(ball_en), 32'd1);
        chk("play_ball_rst", 32'(ball_reset), 32'd0);

        // Six ticks in play: six player steps, three AI steps
        pcount = 0; acount = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1);
            pcount += int'(player_move_en); acount += int'(ai_move_en);
            cyc();
            pcount += int'(player_move_en); acount += int'(ai_move_en);
        end
        chk("player_pulses", 32'(pcount), 32'd6);
        chk("ai_pulses", 32'(acount), 32'd3);

        // Player scores, serves again, scores to win
        cyc(0, 0, 1);
        chk("pt1_score", 32'(score_player), 32'd1);
        chk("pt1_dir", 32'(serve_dir), 32'd1);
        chk("pt1_state", 32'(state), 32'(S_POINT));
        ticks(PNTN);
        chk("pt1_serve", 32'(state), 32'(S_SERVE));
        ticks(SRVN);
        cyc(0, 0, 1);
        chk("win_score", 32'(score_player), 32'd2);
        chk("win_over", 32'(game_over), 32'd1);
        chk("win_winner", 32'(winner), 32'd0);
        chk("win_state", 32'(state), 32'(S_OVER));
        ticks(2);

        // Restart from OVER, then a double miss replays the point
        press_start();
        chk("restart_scores", 32'(score_player), 32'd0);
        ticks(SRVN);
        cyc(0, 1, 1);
        chk("double_state", 32'(state), 32'(S_POINT));
        chk("double_sp", 32'(score_player), 32'd0);
        chk("double_sa", 32'(score_ai), 32'd0);
        chk("double_dir", 32'(serve_dir), 32'd0);
        ticks(PNTN + SRVN);

        // Pause ignores misses and freezes paddles
        pause_lvl = 1'b1; cyc();
        chk("pause_state", 32'(state), 32'(S_PAUSE));
        chk("pause_ball_en", 32'(ball_en), 32'd0);
        pause_lvl = 1'b0;
        cyc(0, 1, 0);
        chk("pause_miss", 32'(score_ai), 32'd0);
        ticks(2);
        press_pause();
        chk("resume_state", 32'(state), 32'(S_PLAY));

        // Reach 1-1 in play, then reset
        cyc(0, 0, 1);
        ticks(PNTN + SRVN);
        cyc(0, 1, 0);
        chk("one_all_sa", 32'(score_ai), 32'd1);
        ticks(PNTN + SRVN);
        chk("one_all_play", 32'(state), 32'(S_PLAY));
        cyc(0, 0, 0, 1);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_sp", 32'(score_player), 32'd0);
        chk("rst_sa", 32'(score_ai), 32'd0);
        chk("rst_ball_reset", 32'(ball_reset), 32'd1);

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            bit ft, ml, mr, rs;
            ft = ($urandom_range(0, 2) == 0);
            ml = ($urandom_range(0, 11) == 0);
            mr = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 9) == 0) start_lvl = ~start_lvl;
            if ($urandom_range(0, 7) == 0) pause_lvl = ~pause_lvl;
            cyc(ft, ml, mr, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
